// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, WAIT_I, WAIT_D)
//   owner_t     : which requester owns the current selection
//   BE_W        : byte-enable width of the memory port
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   localparam int BE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of consecutive cycles the I-side was
// left waiting.
//   clk, rst : clock, synchronous active-high reset
//   inc      : I-side requesting and not granted this cycle
//   clr      : I-side granted or not requesting (wins over inc)
//   starved  : count has reached STARVE_LIMIT
module arb_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic starved
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] cnt;

   // Saturate at the limit; anything above it carries no extra meaning.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && (cnt != CW'(STARVE_LIMIT)))
         cnt <= cnt + 1'b1;
   end

   assign starved = (cnt >= CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single instruction/data memory port between the
// fetch stage (I-side) and the memory stage (D-side). One read outstanding.
//   clk, rst                       : clock, synchronous active-high reset
//   if_req/if_addr                 : fetch read request
//   if_gnt/if_rvalid/if_rdata      : fetch accept and read response
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata : data request
//   dm_gnt/dm_rvalid/dm_rdata      : data accept and read response
//   mem_req/we/be/addr/wdata       : request forwarded to memory
//   mem_ready/mem_rvalid/mem_rdata : memory accept and read response
//   protocol_err                   : sticky, response seen with no read outstanding
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [BE_W-1:0]       dm_be,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_gnt,
   output logic                  dm_rvalid,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [BE_W-1:0]       mem_be,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  protocol_err
);

   arb_state_t state;
   owner_t     win;
   logic       sel;
   logic       issue;
   logic       accept;
   logic       starved;
   logic       perr;

   // D-side normally wins; a starved I-side takes priority over it.
   always_comb begin
      win = OWN_D;
      sel = 1'b0;
      if (if_req && (!dm_req || starved)) begin
         win = OWN_I;
         sel = 1'b1;
      end else if (dm_req) begin
         win = OWN_D;
         sel = 1'b1;
      end
   end

   // Issue only from IDLE; a WAIT state blocks until its response arrives.
   assign issue  = !rst && (state == IDLE) && sel;
   assign accept = issue && mem_ready;

   assign mem_req   = issue;
   assign mem_we    = issue && (win == OWN_D) && dm_we;
   assign mem_be    = !issue ? '0 : ((win == OWN_I) ? {BE_W{1'b1}} : dm_be);
   assign mem_addr  = !issue ? '0 : ((win == OWN_I) ? if_addr : dm_addr);
   assign mem_wdata = (issue && (win == OWN_D)) ? dm_wdata : '0;

   assign if_gnt = accept && (win == OWN_I);
   assign dm_gnt = accept && (win == OWN_D);

   assign if_rvalid = !rst && (state == WAIT_I) && mem_rvalid;
   assign dm_rvalid = !rst && (state == WAIT_D) && mem_rvalid;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

   assign protocol_err = perr && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         perr  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A response with nothing outstanding is dropped and flagged.
               if (mem_rvalid)
                  perr <= 1'b1;
               if (if_gnt)
                  state <= WAIT_I;
               else if (dm_gnt && !dm_we)
                  state <= WAIT_D;
            end
            WAIT_I, WAIT_D: begin
               if (mem_rvalid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Waiting in WAIT states also counts as being denied.
   arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .rst     (rst),
      .inc     (if_req && !if_gnt),
      .clr     (if_gnt || !if_req),
      .starved (starved)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_req, mem_we, mem_ready, mem_rvalid;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        protocol_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_e;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every forwarded response must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && (if_rvalid || dm_rvalid)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected if_rvalid=%0b dm_rvalid=%0b", if_rvalid, dm_rvalid);
         end else begin
            mon_e = exp_q.pop_front();
            if ({if_rvalid, dm_rvalid} !== (mon_e.is_d ? 2'b01 : 2'b10) ||
                (mon_e.is_d ? dm_rdata : if_rdata) !== mon_e.data) begin
               errors++;
               $display("FAIL rsp_route got if=%0b/%h dm=%0b/%h exp is_d=%0b data=%h",
                        if_rvalid, if_rdata, dm_rvalid, dm_rdata, mon_e.is_d, mon_e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = '0;
      dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1;
      if_req = 1; if_addr = 32'h10;
      dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h20; dm_wdata = 32'h55;
      mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h77;
      @(negedge clk);
      checks++;
      if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, protocol_err} !== 7'b0 ||
          mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
          if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs gnt=%0b%0b rv=%0b%0b req=%0b we=%0b be=%h addr=%h perr=%0b exp all 0",
                  if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, mem_addr, protocol_err);
      end
      step();
      rst = 0;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (protocol_err !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_release perr=%0b req=%0b exp 0 0", protocol_err, mem_req);
      end
      step();
   endtask

   task automatic test_fetch();
      if_req = 1; if_addr = 32'h0; mem_ready = 1;
      @(negedge clk);
      checks++;
      if ({if_gnt, dm_gnt, mem_req, mem_we} !== 4'b1010 || mem_addr !== 32'h0 || mem_be !== 4'hF) begin
         errors++;
         $display("FAIL fetch_grant gnt=%0b%0b req=%0b we=%0b addr=%h be=%h exp 10 1 0 0 f",
                  if_gnt, dm_gnt, mem_req, mem_we, mem_addr, mem_be);
      end
      step();
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
      exp_q.push_back('{1'b0, 32'h00500093});
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || dm_rvalid !== 1'b0 ||
          dm_rdata !== 32'h0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL fetch_resp if_rv=%0b if_rd=%h dm_rv=%0b dm_rd=%h req=%0b exp 1 00500093 0 0 0",
                  if_rvalid, if_rdata, dm_rvalid, dm_rdata, mem_req);
      end
      step();
      mem_rvalid = 0; if_req = 1; mem_ready = 0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL fetch_idle req=%0b gnt=%0b exp 1 0", mem_req, if_gnt);
      end
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_dside_priority();
      if_req = 1; if_addr = 32'h44;
      dm_req = 1; dm_we = 0; dm_addr = 32'h100; mem_ready = 1;
      @(negedge clk);
      checks++;
      if ({if_gnt, dm_gnt, mem_we} !== 3'b010 || mem_addr !== 32'h100) begin
         errors++;
         $display("FAIL dside_win gnt=%0b%0b we=%0b addr=%h exp 01 0 100", if_gnt, dm_gnt, mem_we, mem_addr);
      end
      step();
      dm_req = 0;
      @(negedge clk);
      checks++;
      if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL dside_wait req=%0b gnt=%0b%0b rv=%0b%0b exp all 0",
                  mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid);
      end
      step();
      mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
      exp_q.push_back('{1'b1, 32'hCAFE0001});
      @(negedge clk);
      checks++;
      if ({dm_rvalid, if_rvalid, mem_req} !== 3'b100 || dm_rdata !== 32'hCAFE0001 || if_rdata !== 32'h0) begin
         errors++;
         $display("FAIL dside_resp dm_rv=%0b if_rv=%0b req=%0b dm_rd=%h if_rd=%h exp 1 0 0 cafe0001 0",
                  dm_rvalid, if_rvalid, mem_req, dm_rdata, if_rdata);
      end
      step();
      mem_rvalid = 0;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || mem_addr !== 32'h44) begin
         errors++;
         $display("FAIL dside_then_i gnt=%0b addr=%h exp 1 44", if_gnt, mem_addr);
      end
      step();
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'h11112222;
      exp_q.push_back('{1'b0, 32'h11112222});
      @(negedge clk);
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_starvation();
      bit          exp_ig, exp_dg, exp_req, chk_addr;
      logic [31:0] exp_addr;
      dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'h12345678;
      if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h0000ABCD;
      for (int k = 0; k < 7; k++) begin
         if_req = (k != 5);
         mem_rvalid = (k == 5);
         if (k == 5) exp_q.push_back('{1'b0, 32'h0000ABCD});
         exp_ig = (k == 4);
         exp_dg = (k < 4) || (k == 6);
         exp_req = (k != 5);
         chk_addr = (k != 5);
         exp_addr = (k == 4) ? 32'h40 : 32'h200;
         @(negedge clk);
         checks++;
         if ({if_gnt, dm_gnt, mem_req} !== {exp_ig, exp_dg, exp_req} ||
             (chk_addr && mem_addr !== exp_addr)) begin
            errors++;
            $display("FAIL starve_k%0d gnt=%0b%0b req=%0b addr=%h exp %0b%0b %0b %h",
                     k, if_gnt, dm_gnt, mem_req, mem_addr, exp_ig, exp_dg, exp_req, exp_addr);
         end
         step();
      end
      idle_inputs();
      step();
   endtask

   task automatic test_write_stall();
      dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h300; dm_wdata = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         @(negedge clk);
         checks++;
         if (dm_gnt !== (k == 3) || mem_req !== 1'b1 || mem_we !== 1'b1 ||
             mem_be !== 4'b0011 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h300) begin
            errors++;
            $display("FAIL wstall_k%0d gnt=%0b req=%0b we=%0b be=%h wd=%h addr=%h exp %0b 1 1 3 deadbeef 300",
                     k, dm_gnt, mem_req, mem_we, mem_be, mem_wdata, mem_addr, (k == 3));
         end
         step();
      end
      idle_inputs();
      if_req = 1; if_addr = 32'h88;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 32'h88) begin
         errors++;
         $display("FAIL wstall_idle req=%0b we=%0b be=%h addr=%h exp 1 0 f 88", mem_req, mem_we, mem_be, mem_addr);
      end
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_spurious();
      mem_rvalid = 1; mem_rdata = 32'h99999999;
      @(negedge clk);
      checks++;
      if ({if_rvalid, dm_rvalid, protocol_err} !== 3'b000) begin
         errors++;
         $display("FAIL spur_drop rv=%0b%0b perr=%0b exp 00 0", if_rvalid, dm_rvalid, protocol_err);
      end
      step();
      mem_rvalid = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky_k%0d perr=%0b exp 1", k, protocol_err);
         end
         step();
      end
      rst = 1;
      @(negedge clk);
      checks++;
      if (protocol_err !== 1'b0) begin
         errors++;
         $display("FAIL spur_rst_force perr=%0b exp 0", protocol_err);
      end
      step();
      rst = 0;
      @(negedge clk);
      checks++;
      if (protocol_err !== 1'b0) begin
         errors++;
         $display("FAIL spur_rst_clear perr=%0b exp 0", protocol_err);
      end
      step();
   endtask

   task automatic test_reset_in_wait();
      if_req = 1; if_addr = 32'h80; mem_ready = 1;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rwait_grant gnt=%0b exp 1", if_gnt);
      end
      step();
      if_req = 0; mem_ready = 0; rst = 1;
      @(negedge clk);
      step();
      rst = 0;
      @(negedge clk);
      step();
      @(negedge clk);
      step();
      mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      checks++;
      if ({if_rvalid, dm_rvalid, protocol_err} !== 3'b000) begin
         errors++;
         $display("FAIL rwait_late rv=%0b%0b perr=%0b exp 00 0", if_rvalid, dm_rvalid, protocol_err);
      end
      step();
      mem_rvalid = 0;
      @(negedge clk);
      checks++;
      if (protocol_err !== 1'b1) begin
         errors++;
         $display("FAIL rwait_perr perr=%0b exp 1", protocol_err);
      end
      step();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_fetch();
      test_dside_priority();
      test_starvation();
      test_write_stall();
      test_spurious();
      test_reset_in_wait();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rsp_missing pending=%0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single unified instruction/data memory port between the fetch stage (I-side) and the memory stage (D-side). It arbitrates per cycle, tracks the one outstanding read, and routes the read response back to its owner. The I-side gets a starvation guard so it is not locked out by back-to-back loads and stores. It sits in `top` between the fetch/memory stages and the memory model; stall logic consumes `if_gnt` and `dm_gnt`.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data word width
- `STARVE_LIMIT`, 4, consecutive denied I-side cycles before I-side wins priority (≥1)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch read request
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DATA_WIDTH  fetch read data
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = write, 0 = read
- `dm_be`  in  4  byte enables (write)
- `dm_addr`  in  ADDR_WIDTH  data address
- `dm_wdata`  in  DATA_WIDTH  write data
- `dm_gnt`  out  1  data request accepted this cycle
- `dm_rvalid`  out  1  data read data valid
- `dm_rdata`  out  DATA_WIDTH  data read data
- `mem_req`  out  1  request to memory
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/4/ADDR_WIDTH/DATA_WIDTH  forwarded from the selected requester
- `mem_ready`  in  1  memory accepts request this cycle
- `mem_rvalid`  in  1  read response valid (≥1 cycle after acceptance)
- `mem_rdata`  in  DATA_WIDTH  read response data
- `protocol_err`  out  1  sticky: `mem_rvalid` seen with no read outstanding

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D. Only one read may be outstanding at a time.
- **IDLE, selection:**
  - D-side wins if both request, unless `starve_cnt >= STARVE_LIMIT`; then I-side wins.
  - `mem_req` = selected requester present. `mem_*` fields are muxed from the winner. For an I-side winner: `mem_we=0`, `mem_be=4'hF`.
- **Grant:** winner's `gnt` = `mem_req && mem_ready`, combinational, same cycle. The loser's `gnt` = 0.
- **On a grant:**
  - I read → WAIT_I; D read → WAIT_D.
  - D write → stay IDLE; a write completes on acceptance and has no response.
- **WAIT_x:** `mem_req=0`, both `gnt=0`. On `mem_rvalid`: drive `x_rvalid=1` and `x_rdata=mem_rdata` combinationally in that cycle, then go to IDLE. No new issue happens in the `mem_rvalid` cycle.
- **Unused response outputs:** `if_rdata`/`dm_rdata` are 0 when the corresponding rvalid is 0.
- **starve_cnt** (width `$clog2(STARVE_LIMIT+1)`, saturating):
  - Cleared on an I grant or when `if_req=0`.
  - Otherwise increments each cycle `if_req=1 && !if_gnt`, including WAIT cycles.
- **Spurious response:** `mem_rvalid` in IDLE is dropped (no rvalid forwarded) and sets `protocol_err` on the next edge. It stays set until `rst`.
- **Reset:**
  - While `rst=1`, all outputs are forced to 0.
  - Next state is IDLE, with `starve_cnt=0` and `protocol_err=0`.
  - Reset mid-WAIT abandons the read; a late `mem_rvalid` then counts as spurious.

## Timing
- Grant latency 0 cycles: `gnt` is asserted in the cycle `mem_ready` is high.
- Read latency is memory latency plus 0 cycles; response routing is combinational.
- Minimum of 2 cycles between back-to-back reads: issue, then response (when the response comes in the next cycle), then next issue.
- Writes can issue every cycle.
- Requesters must hold `req` and payload stable until `gnt`. The arbiter does not latch the payload.
- Registered state: FSM state, `starve_cnt`, `protocol_err`. All other outputs are combinational from state and inputs.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, WAIT_I, WAIT_D}
  - `owner_t` enum {OWN_I, OWN_D}
  - `localparam` for byte-enable width (4)
- Sub-module `arb_starve_ctr`: saturating counter with `inc`/`clr` inputs and a `starved` flag (`cnt >= STARVE_LIMIT`). It is instantiated once.

## Test plan
- Reset, then `if_req=1`, `if_addr=0x0`, `mem_ready=1`, response after 1 cycle with `0x00500093` → `if_gnt`=1 in cycle 0, `if_rvalid`=1 with `if_rdata=0x00500093` in cycle 1, IDLE in cycle 2.
- `if_req` and `dm_req` (read, `0x100`) both high, `starve_cnt=0` → `dm_gnt`=1, `if_gnt`=0, `mem_addr=0x100`. The `dm_rvalid` response goes only to the D-side.
- `dm_req` write held high for 6 cycles with `if_req`, `STARVE_LIMIT=4` → D wins for 4 cycles, I granted on the 5th, `starve_cnt`=0 after.
- D write `be=4'b0011`, `wdata=0xDEADBEEF`, `mem_ready=0` for 3 cycles, then 1 → `dm_gnt` only in the 4th cycle, `mem_be=0011`, FSM stays IDLE.
- `mem_rvalid` pulse in IDLE → no rvalid forwarded, `protocol_err`=1 next cycle, cleared only by `rst`.
- `rst` asserted during WAIT_I, `mem_rvalid` arrives 2 cycles after release → `if_rvalid` stays 0, `protocol_err`=1.
